// File: rtl/rx_arb_pkg.sv
// Shared types and helpers for the receiver I/Q sample arbiter and its round-robin core.
package rx_arb_pkg;

   localparam int unsigned DW_DEFAULT = 24;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEND_I = 2'd1,
      SEND_Q = 2'd2
   } state_t;

   // Ceiling log2, used to size channel indices and to check the tag width
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first pending requester above last_grant, wrapping modulo NRX.
module rr_arbiter
   import rx_arb_pkg::*;
#(
   parameter int unsigned NRX = 2,
   parameter int unsigned IW  = (NRX > 1) ? clog2(NRX) : 1
)(
   input  logic [NRX-1:0] pending,
   input  logic [IW-1:0]  last_grant,
   output logic           grant_valid,
   output logic [IW-1:0]  grant_idx
);

   int unsigned c;

   // last_grant is always < NRX, so a single subtraction performs the wrap
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      c           = 0;
      for (int unsigned i = 1; i <= NRX; i++) begin
         c = 32'(last_grant) + i;
         if (c >= NRX) c = c - NRX;
         if (!grant_valid && pending[IW'(c)]) begin
            grant_valid = 1'b1;
            grant_idx   = IW'(c);
         end
      end
   end

endmodule

// File: rtl/rx_iq_arbiter.sv
// Captures per-receiver I/Q samples and serialises them round-robin as tagged I then Q words.
module rx_iq_arbiter
   import rx_arb_pkg::*;
#(
   parameter int unsigned NRX = 2,
   parameter int unsigned DW  = DW_DEFAULT,
   parameter int unsigned CHW = 3
)(
   input  logic              clock,
   input  logic              reset_n,
   input  logic [NRX-1:0]    rx_enable,
   input  logic [NRX-1:0]    rx_strobe,
   input  logic [NRX*DW-1:0] rx_data_I,
   input  logic [NRX*DW-1:0] rx_data_Q,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DW-1:0]     out_data,
   output logic [CHW-1:0]    out_chan,
   output logic              out_last,
   output logic [NRX-1:0]    overrun,
   input  logic              clear_overrun
);

   localparam int unsigned IW = (NRX > 1) ? clog2(NRX) : 1;

   if (CHW < clog2(NRX)) begin : g_chw_check
      $error("rx_iq_arbiter: CHW too narrow to tag NRX channels");
   end

   state_t         state, state_nxt;
   logic [NRX-1:0] pending, drain, cap, ovr_set;
   logic [DW-1:0]  hold_i [NRX];
   logic [DW-1:0]  hold_q [NRX];
   logic [DW-1:0]  stage_q, stage_q_nxt;
   logic [IW-1:0]  last_grant, last_grant_nxt, grant_idx;
   logic           grant_valid, grant_fire;
   logic           out_valid_nxt, out_last_nxt;
   logic [DW-1:0]  out_data_nxt;
   logic [CHW-1:0] out_chan_nxt;

   rr_arbiter #(.NRX(NRX), .IW(IW)) u_rr (
      .pending     (pending),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   // A grant draining channel k frees its slot, so a same-cycle capture is not an overrun
   always_comb begin
      drain   = '0;
      cap     = '0;
      ovr_set = '0;
      for (int k = 0; k < int'(NRX); k++) begin
         drain[k]   = grant_fire && (grant_idx == IW'(k));
         cap[k]     = rx_strobe[k] && rx_enable[k] && (!pending[k] || drain[k]);
         ovr_set[k] = rx_strobe[k] && rx_enable[k] && pending[k] && !drain[k];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pending <= '0;
         overrun <= '0;
         for (int k = 0; k < int'(NRX); k++) begin
            hold_i[k] <= '0;
            hold_q[k] <= '0;
         end
      end else begin
         pending <= (pending & ~drain) | cap;
         overrun <= (overrun & ~{NRX{clear_overrun}}) | ovr_set;
         for (int k = 0; k < int'(NRX); k++) begin
            if (cap[k]) begin
               hold_i[k] <= rx_data_I[k*DW +: DW];
               hold_q[k] <= rx_data_Q[k*DW +: DW];
            end
         end
      end
   end

   // Next-state and next-output; outputs only change on a grant or a handshake
   always_comb begin
      state_nxt      = state;
      out_valid_nxt  = out_valid;
      out_data_nxt   = out_data;
      out_chan_nxt   = out_chan;
      out_last_nxt   = out_last;
      stage_q_nxt    = stage_q;
      last_grant_nxt = last_grant;
      grant_fire     = 1'b0;
      case (state)
         IDLE: begin
            if (grant_valid) begin
               grant_fire     = 1'b1;
               last_grant_nxt = grant_idx;
               stage_q_nxt    = hold_q[grant_idx];
               out_data_nxt   = hold_i[grant_idx];
               out_chan_nxt   = CHW'(grant_idx);
               out_valid_nxt  = 1'b1;
               out_last_nxt   = 1'b0;
               state_nxt      = SEND_I;
            end
         end
         SEND_I: begin
            if (out_ready) begin
               out_data_nxt = stage_q;
               out_last_nxt = 1'b1;
               state_nxt    = SEND_Q;
            end
         end
         SEND_Q: begin
            if (out_ready) begin
               out_valid_nxt = 1'b0;
               out_last_nxt  = 1'b0;
               state_nxt     = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_chan   <= '0;
         out_last   <= 1'b0;
         stage_q    <= '0;
         last_grant <= IW'(NRX - 1);
      end else begin
         state      <= state_nxt;
         out_valid  <= out_valid_nxt;
         out_data   <= out_data_nxt;
         out_chan   <= out_chan_nxt;
         out_last   <= out_last_nxt;
         stage_q    <= stage_q_nxt;
         last_grant <= last_grant_nxt;
      end
   end

endmodule
